// File: rtl/alu_defs.sv
// Shared ALU definitions: multiplier FSM state encoding and step count.
package alu_defs;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_RUN  = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_t;

  localparam int MUL_STEPS = 32;

endpackage

// File: rtl/adder32.sv
// 32-bit ripple-carry adder built from a chain of full adders.
module adder32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout,
  output logic        overflow
);

  logic [32:0] carry;

  assign carry[0] = cin;

  genvar i;
  generate
    for (i = 0; i < 32; i++) begin : g_fa
      assign sum[i]       = a[i] ^ b[i] ^ carry[i];
      assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
  endgenerate

  assign cout     = carry[32];
  assign overflow = carry[32] ^ carry[31];

endmodule

// File: rtl/seq_multiplier32.sv
// Multi-cycle 32x32->64 unsigned shift-and-add multiplier around adder32.
// Optional macro MULT_EARLY_EXIT_EN: finish as soon as the remaining multiplier bits are zero.
module seq_multiplier32
  import alu_defs::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic                 overflow
);

  generate
    if (WIDTH != 32) begin : g_width_check
      $error("seq_multiplier32 supports WIDTH == 32 only");
    end
  endgenerate

  mul_state_t  state;
  logic [31:0] mcand;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [5:0]  count;

  logic [31:0] addend;
  logic [31:0] sum;
  logic        cout;
  logic        add_ovf_unused;

  // AND row: the multiplicand reaches the adder only when the current multiplier bit is set.
  assign addend = mcand & {32{lo[0]}};

  adder32 u_adder (
    .a        (hi),
    .b        (addend),
    .cin      (1'b0),
    .sum      (sum),
    .cout     (cout),
    .overflow (add_ovf_unused)
  );

  assign product  = {hi, lo};
  assign overflow = |hi;

`ifdef MULT_EARLY_EXIT_EN
  logic [31:0] remain_mask;
  logic        early_exit;
  logic [6:0]  shamt;
  logic [63:0] flushed;

  // Low (32-count) bits of lo still hold unconsumed multiplier bits.
  assign remain_mask = 32'hFFFF_FFFF >> count;
  assign early_exit  = ((lo & remain_mask) == 32'd0);
  assign shamt       = 7'd32 - {1'b0, count};
  assign flushed     = {hi, lo} >> shamt;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= MUL_IDLE;
      mcand <= '0;
      hi    <= '0;
      lo    <= '0;
      count <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        MUL_IDLE, MUL_DONE: begin
          done <= 1'b0;
          if (start) begin
            mcand <= A;
            hi    <= '0;
            lo    <= B;
            count <= '0;
            busy  <= 1'b1;
            state <= MUL_RUN;
          end else begin
            state <= MUL_IDLE;
          end
        end
        MUL_RUN: begin
`ifdef MULT_EARLY_EXIT_EN
          if (early_exit) begin
            {hi, lo} <= flushed;
            count    <= count + 6'd1;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= MUL_DONE;
          end else
`endif
          begin
            // 65-bit logical right shift of {cout, sum, lo}.
            {hi, lo} <= {cout, sum, lo[31:1]};
            count    <= count + 6'd1;
            if (count == 6'(MUL_STEPS - 1)) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= MUL_DONE;
            end
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= MUL_IDLE;
        end
      endcase
    end
  end

endmodule
